equiv_sweep_ctrl: RTL and testbench



---
 rtl/equiv_sweep_ctrl.sv | 138 +++++++++++++
 tb/tb_equiv_sweep_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/equiv_sweep_ctrl.sv
// equiv_sweep_ctrl: sweeps a shared input vector through a golden and a
// revised combinational netlist, compares their outputs after a settle
// interval, captures the first mismatch and reports a pass/fail verdict.
//
// Handshake: start is a one-cycle request, accepted only in IDLE or in a
// DONE cycle after the done pulse. busy rises the cycle after acceptance and
// falls together with the one-cycle done pulse. Requests while busy, or in the
// done-pulse cycle, are dropped.
module equiv_sweep_ctrl #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 2,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop_on_fail,
    output logic [N_IN-1:0]  vec_out,
    input  logic [N_OUT-1:0] golden_o,
    input  logic [N_OUT-1:0] revised_o,
    output logic             busy,
    output logic             done,
    output logic             equiv,
    output logic [N_IN-1:0]  fail_vec,
    output logic [N_OUT-1:0] fail_diff,
    output logic [N_IN:0]    vec_count
);

    // Settle counter holds SETTLE-1 down to 0; at least one bit wide.
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE - 1);
    localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
    localparam logic [N_IN:0]   VC_ONE      = (N_IN + 1)'(1);
    localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CMP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] settle_cnt;
    logic          stop_latched;

    logic          mismatch;
    logic          last_vec;
    logic          accept;
    logic          compare;
    logic          finish;

    assign mismatch = (golden_o != revised_o);
    assign last_vec = &vec_out;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (accept) state_nxt = ST_WAIT;
            ST_WAIT:          if (settle_cnt == '0) state_nxt = ST_CMP;
            ST_CMP:           state_nxt = finish ? ST_DONE : ST_WAIT;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // Per-state action decode; the done-pulse cycle blocks a restart.
    always_comb begin
        accept  = 1'b0;
        compare = 1'b0;
        finish  = 1'b0;
        case (state)
            ST_IDLE: accept = start;
            ST_DONE: accept = start && !done;
            ST_CMP: begin
                compare = 1'b1;
                finish  = (mismatch && stop_latched) || last_vec;
            end
            default: ;
        endcase
    end

    // Registered outputs, settle counter and first-mismatch capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_out      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            equiv        <= 1'b1;
            fail_vec     <= '0;
            fail_diff    <= '0;
            vec_count    <= '0;
            settle_cnt   <= '0;
            stop_latched <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                vec_out      <= '0;
                vec_count    <= '0;
                equiv        <= 1'b1;
                fail_vec     <= '0;
                fail_diff    <= '0;
                stop_latched <= stop_on_fail;
                settle_cnt   <= SETTLE_LOAD;
                busy         <= 1'b1;
            end
            if (state == ST_WAIT && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - CNT_ONE;
            end
            if (compare) begin
                vec_count <= vec_count + VC_ONE;
                if (mismatch && equiv) begin
                    equiv     <= 1'b0;
                    fail_vec  <= vec_out;
                    fail_diff <= golden_o ^ revised_o;
                end
                if (finish) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end else begin
                    vec_out    <= vec_out + VEC_ONE;
                    settle_cnt <= SETTLE_LOAD;
                end
            end
        end
    end

endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
// Bench for equiv_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) share the
// control inputs and a pair of truth-table netlists; a sweep-level model
// predicts verdict, capture, vector count and done latency.
module tb_equiv_sweep_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stop_on_fail = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    // Netlist truth tables, index = {I1, I0}, entry = {O1, O0}.
    logic [1:0] gold_tt [4];
    logic [1:0] rev_tt  [4];

    logic [1:0] d1_vec, d1_gold, d1_rev, d1_fvec, d1_fdiff;
    logic [2:0] d1_cnt;
    logic       d1_busy, d1_done, d1_equiv;
    logic [1:0] d3_vec, d3_gold, d3_rev, d3_fvec, d3_fdiff;
    logic [2:0] d3_cnt;
    logic       d3_busy, d3_done, d3_equiv;

    assign d1_gold = gold_tt[d1_vec];
    assign d1_rev  = rev_tt[d1_vec];
    assign d3_gold = gold_tt[d3_vec];
    assign d3_rev  = rev_tt[d3_vec];

    equiv_sweep_ctrl #(.N_IN(2), .N_OUT(2), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop_on_fail(stop_on_fail),
        .vec_out(d1_vec), .golden_o(d1_gold), .revised_o(d1_rev),
        .busy(d1_busy), .done(d1_done), .equiv(d1_equiv),
        .fail_vec(d1_fvec), .fail_diff(d1_fdiff), .vec_count(d1_cnt)
    );

    equiv_sweep_ctrl #(.N_IN(2), .N_OUT(2), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop_on_fail(stop_on_fail),
        .vec_out(d3_vec), .golden_o(d3_gold), .revised_o(d3_rev),
        .busy(d3_busy), .done(d3_done), .equiv(d3_equiv),
        .fail_vec(d3_fvec), .fail_diff(d3_fdiff), .vec_count(d3_cnt)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Revised netlist: 0 equivalent, 1 O1 tied to I1, 2 O0 = I0&I1.
    task automatic set_rev(input int mode);
        for (int v = 0; v < 4; v++) begin
            logic i0, i1;
            i0 = v[0];
            i1 = v[1];
            case (mode)
                1:       rev_tt[v] = {i1, i0 | i1};
                2:       rev_tt[v] = {~i1, i0 & i1};
                default: rev_tt[v] = {~i1, i0 | i1};
            endcase
        end
    endtask

    // Sweep-level reference: walk the vectors, first difference wins.
    task automatic model(input logic stop, output logic eq, output logic [1:0] fv,
                         output logic [1:0] fd, output int cnt);
        eq = 1'b1; fv = '0; fd = '0; cnt = 0;
        for (int v = 0; v < 4; v++) begin
            cnt++;
            if (gold_tt[v] !== rev_tt[v]) begin
                if (eq) begin
                    eq = 1'b0;
                    fv = v[1:0];
                    fd = gold_tt[v] ^ rev_tt[v];
                end
                if (stop) break;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_d1_busy"},  d1_busy, 0);
        check({tag, "_d1_vec"},   d1_vec, 0);
        check({tag, "_d1_equiv"}, d1_equiv, 1);
        check({tag, "_d1_cnt"},   d1_cnt, 0);
        check({tag, "_d1_done"},  d1_done, 0);
        check({tag, "_d1_fvec"},  d1_fvec, 0);
        check({tag, "_d1_fdiff"}, d1_fdiff, 0);
        check({tag, "_d3_busy"},  d3_busy, 0);
        check({tag, "_d3_vec"},   d3_vec, 0);
        check({tag, "_d3_equiv"}, d3_equiv, 1);
        check({tag, "_d3_cnt"},   d3_cnt, 0);
    endtask

    // One sweep on both instances. poke_busy: cycle to pulse start mid-sweep
    // (0 = none); poke_done: pulse start in the SETTLE=1 done-pulse cycle.
    task automatic run_sweep(input string tag, input logic stop, input int poke_busy,
                             input bit poke_done);
        logic e_eq;
        logic [1:0] e_fv, e_fd;
        int e_cnt, lat1, lat3, cyc;
        model(stop, e_eq, e_fv, e_fd, e_cnt);
        @(negedge clk);
        start = 1'b1;
        stop_on_fail = stop;
        @(negedge clk);
        start = 1'b0;
        stop_on_fail = 1'($urandom_range(0, 1));
        cyc = 1;
        check({tag, "_busy_rise"},  d1_busy, 1);
        check({tag, "_equiv_init"}, d1_equiv, 1);
        check({tag, "_cnt_init"},   d1_cnt, 0);
        check({tag, "_d3_busy"},    d3_busy, 1);
        lat1 = 0;
        lat3 = 0;
        while ((lat1 == 0 || lat3 == 0) && cyc < 200) begin
            if (lat1 == 0 && d1_done) begin
                lat1 = cyc;
                check({tag, "_d1_equiv"}, d1_equiv, e_eq);
                check({tag, "_d1_fvec"},  d1_fvec, e_fv);
                check({tag, "_d1_fdiff"}, d1_fdiff, e_fd);
                check({tag, "_d1_cnt"},   d1_cnt, e_cnt);
                check({tag, "_d1_vec"},   d1_vec, e_cnt - 1);
                check({tag, "_d1_busy"},  d1_busy, 0);
            end else if (lat1 != 0 && cyc == lat1 + 1) begin
                check({tag, "_d1_pulse"}, d1_done, 0);
                check({tag, "_d1_idle"},  d1_busy, 0);
            end
            if (lat3 == 0 && d3_done) begin
                lat3 = cyc;
                check({tag, "_d3_equiv"}, d3_equiv, e_eq);
                check({tag, "_d3_fvec"},  d3_fvec, e_fv);
                check({tag, "_d3_fdiff"}, d3_fdiff, e_fd);
                check({tag, "_d3_cnt"},   d3_cnt, e_cnt);
            end
            start = (cyc == poke_busy) || (poke_done && lat1 != 0 && cyc == lat1);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_d1_latency"}, lat1, e_cnt * 2 + 1);
        check({tag, "_d3_latency"}, lat3, e_cnt * 4 + 1);
        check({tag, "_d3_pulse"}, d3_done, 0);
        check({tag, "_d1_still_idle"}, d1_busy, 0);
        check({tag, "_d1_cnt_hold"}, d1_cnt, e_cnt);
    endtask

    initial begin
        for (int v = 0; v < 4; v++) begin
            logic i0, i1;
            i0 = v[0];
            i1 = v[1];
            gold_tt[v] = {~i1, i0 | (~i0 & i1)};
        end
        set_rev(0);

        // Reset.
        #12;
        check_reset_values("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("idle");

        run_sweep("equiv_full", 1'b0, 0, 1'b0);
        set_rev(1);
        run_sweep("o1_run", 1'b0, 0, 1'b0);
        run_sweep("o1_stop", 1'b1, 0, 1'b0);
        set_rev(2);
        run_sweep("late_stop", 1'b1, 0, 1'b0);
        run_sweep("late_run", 1'b0, 0, 1'b0);

        // Asynchronous reset in the middle of a sweep.
        set_rev(0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && d1_vec != 2'd2; i++) @(negedge clk);
        check("rst_reach_vec2", d1_vec, 2);
        check("rst_busy_before", d1_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep("after_rst", 1'b0, 0, 1'b0);

        // Start while busy, start in the done cycle, then re-arm.
        set_rev(1);
        run_sweep("busy_poke", 1'b0, 4, 1'b1);
        set_rev(0);
        run_sweep("rearm", 1'b0, 0, 1'b0);

        // Random revised netlists.
        for (int n = 0; n < 8; n++) begin
            for (int v = 0; v < 4; v++) begin
                rev_tt[v] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : gold_tt[v];
            end
            run_sweep("rand", 1'($urandom_range(0, 1)), 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
